// File: rtl/test_eval_sequencer_if.sv
// Handshake bundle between top-level control, label memory, network core and the
// test-set evaluation sequencer.
interface test_eval_sequencer_if;
  logic        start;
  logic [31:0] num_tests;
  logic [31:0] test_sel;
  logic [7:0]  label;
  logic        nn_start;
  logic        nn_done;
  logic [7:0]  nn_pred;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        timeout_err;
  logic [31:0] correct_cnt;
  logic [31:0] tested_cnt;

  modport slave (
    input  start, num_tests, label, nn_done, nn_pred,
    output test_sel, nn_start, busy, done, cfg_err, timeout_err, correct_cnt, tested_cnt
  );

  modport master (
    output start, num_tests, label, nn_done, nn_pred,
    input  test_sel, nn_start, busy, done, cfg_err, timeout_err, correct_cnt, tested_cnt
  );
endinterface

// File: rtl/test_eval_sequencer.sv
// Walks test indices 1..n, launches one inference per index, compares the prediction
// against the stored label and accumulates correct/tested counts. All outputs registered.
module test_eval_sequencer #(
  parameter int unsigned MAX_TESTS   = 750,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic                  clk,
  input logic                  rst,
  test_eval_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCompare, StFinish} state_e;

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] test_sel_q, test_sel_d;
  logic [7:0]  label_q, label_d;
  logic [7:0]  pred_q, pred_d;
  logic [31:0] timer_q, timer_d;
  logic        miss_q, miss_d;
  logic        nn_start_q, nn_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] correct_q, correct_d;
  logic [31:0] tested_q, tested_d;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    test_sel_d    = test_sel_q;
    label_d       = label_q;
    pred_d        = pred_q;
    timer_d       = timer_q;
    miss_d        = miss_q;
    busy_d        = busy_q;
    cfg_err_d     = cfg_err_q;
    timeout_err_d = timeout_err_q;
    correct_d     = correct_q;
    tested_d      = tested_q;

    unique case (state_q)
      StIdle: begin
        // busy_q is only still high here during the done pulse, which must ignore start
        busy_d = 1'b0;
        if (bus.start && !busy_q) begin
          n_d           = bus.num_tests;
          correct_d     = '0;
          tested_d      = '0;
          cfg_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          if (bus.num_tests == 32'd0 || bus.num_tests > MAX_TESTS) begin
            cfg_err_d = 1'b1;
            state_d   = StFinish;
          end else begin
            test_sel_d = 32'd1;
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        label_d = bus.label;
        timer_d = '0;
        miss_d  = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.nn_done) begin
          pred_d  = bus.nn_pred;
          state_d = StCompare;
        end else if (TIMEOUT_CYC != 0 && timer_q == TIMEOUT_CYC - 32'd1) begin
          timeout_err_d = 1'b1;
          miss_d        = 1'b1;
          state_d       = StCompare;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StCompare: begin
        tested_d = tested_q + 32'd1;
        if (!miss_q && pred_q == label_q) begin
          correct_d = correct_q + 32'd1;
        end
        if (test_sel_q == n_q) begin
          state_d = StFinish;
        end else begin
          test_sel_d = test_sel_q + 32'd1;
          state_d    = StIssue;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Registered strobes: nn_start coincides with ISSUE, done follows FINISH.
    nn_start_d = (state_d == StIssue);
    done_d     = (state_q == StFinish);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      n_q           <= '0;
      test_sel_q    <= 32'd1;
      label_q       <= '0;
      pred_q        <= '0;
      timer_q       <= '0;
      miss_q        <= 1'b0;
      nn_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      correct_q     <= '0;
      tested_q      <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      test_sel_q    <= test_sel_d;
      label_q       <= label_d;
      pred_q        <= pred_d;
      timer_q       <= timer_d;
      miss_q        <= miss_d;
      nn_start_q    <= nn_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      timeout_err_q <= timeout_err_d;
      correct_q     <= correct_d;
      tested_q      <= tested_d;
    end
  end

  assign bus.test_sel    = test_sel_q;
  assign bus.nn_start    = nn_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.correct_cnt = correct_q;
  assign bus.tested_cnt  = tested_q;

endmodule

// File: tb/tb_test_eval_sequencer.sv
// Bench for test_eval_sequencer: models label memory and a network with per-test latency,
// and predicts counts, flags and run length from the per-test table.
module tb_test_eval_sequencer;

  localparam int unsigned TO   = 8;
  localparam int unsigned MaxT = 750;
  localparam int unsigned Never = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  test_eval_sequencer_if bus ();

  test_eval_sequencer #(
    .MAX_TESTS  (MaxT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  lbl_mem  [0:1023];
  logic [7:0]  pred_mem [0:1023];
  int unsigned dly_mem  [0:1023];  // > TO: the network never answers this test

  logic [9:0] sel_idx;
  assign sel_idx   = 10'(bus.test_sel - 32'd1);
  assign bus.label = lbl_mem[sel_idx];

  int unsigned passed = 0;
  int unsigned total  = 0;

  int unsigned obs_starts, obs_sel_bad, obs_done_cnt, obs_busy_bad, obs_hung;
  int          obs_done_cyc;

  // Reference model: derived directly from the per-test table.
  function automatic int exp_done_cyc(input int unsigned n);
    int c = 2;
    for (int i = 0; i < int'(n); i++) begin
      c += ((dly_mem[i] <= TO) ? int'(dly_mem[i]) : int'(TO)) + 2;
    end
    return c;
  endfunction

  function automatic int unsigned exp_correct(input int unsigned n);
    int unsigned c = 0;
    for (int i = 0; i < int'(n); i++) begin
      if (dly_mem[i] <= TO && pred_mem[i] == lbl_mem[i]) c++;
    end
    return c;
  endfunction

  function automatic bit exp_timeout(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      if (dly_mem[i] > TO) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic fill(input int unsigned n, input int unsigned dmin, input int unsigned dmax);
    for (int i = 0; i < int'(n); i++) begin
      lbl_mem[i]  = 8'($urandom);
      pred_mem[i] = ($urandom_range(0, 1) == 1) ? lbl_mem[i] : lbl_mem[i] + 8'd1;
      dly_mem[i]  = $urandom_range(dmin, dmax);
    end
  endtask

  // Drives one run and acts as the network; observations land in obs_*.
  task automatic run_seq(input int unsigned n, input bit hold_start, input bit stray,
                         input int unsigned abort_at, input int budget);
    int          cyc = 0;
    bit          armed = 1'b0;
    int unsigned cd = 0;
    bit          stray_next = 1'b0;
    int          abort_cd = -1;
    bit          fin = 1'b0;
    logic [9:0]  cur = '0;
    obs_starts = 0; obs_sel_bad = 0; obs_done_cnt = 0; obs_busy_bad = 0; obs_hung = 0;
    obs_done_cyc = -1;
    bus.start = 1'b1;
    bus.num_tests = n;
    bus.nn_done = 1'b0;
    while (!fin) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!hold_start) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) obs_done_cyc = cyc;
        bus.start = 1'b0;
      end
      if (obs_done_cyc < 0 || cyc == obs_done_cyc) begin
        if (bus.busy !== 1'b1) obs_busy_bad++;
      end else if (bus.busy !== 1'b0) begin
        obs_busy_bad++;
      end
      bus.nn_done = 1'b0;
      if (stray_next) begin
        bus.nn_done = 1'b1;
        bus.nn_pred = 8'($urandom);
        stray_next  = 1'b0;
      end
      if (armed) begin
        cd--;
        if (cd == 0) begin
          bus.nn_done = 1'b1;
          bus.nn_pred = pred_mem[cur];
          armed       = 1'b0;
          stray_next  = stray;
        end
      end
      if (bus.nn_start === 1'b1) begin
        obs_starts++;
        if (bus.test_sel !== obs_starts) obs_sel_bad++;
        cur = sel_idx;
        if (dly_mem[cur] <= TO) begin
          armed = 1'b1;
          cd    = dly_mem[cur];
        end
        if (abort_at != 0 && obs_starts == abort_at) abort_cd = 2;
      end else if (abort_cd > 0) begin
        abort_cd--;
        if (abort_cd == 0) begin
          rst = 1'b1;
          bus.nn_done = 1'b0;
          @(posedge clk);
          #1;
          rst = 1'b0;
          fin = 1'b1;
        end
      end
      if (obs_done_cyc >= 0 && cyc >= obs_done_cyc + 4) fin = 1'b1;
      if (cyc >= budget) begin
        obs_hung = 1;
        fin = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.nn_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.num_tests = '0; bus.nn_done = 1'b0; bus.nn_pred = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.test_sel !== 32'd1) $display("FAIL reset_test_sel: got %0d want 1", bus.test_sel); else passed++;
    total++; if ({bus.nn_start, bus.busy, bus.done} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {bus.nn_start, bus.busy, bus.done}); else passed++;
    total++; if ({bus.cfg_err, bus.timeout_err} !== 2'b00) $display("FAIL reset_errs: got %b want 00", {bus.cfg_err, bus.timeout_err}); else passed++;
    total++; if (bus.correct_cnt !== 0 || bus.tested_cnt !== 0) $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.correct_cnt, bus.tested_cnt); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    lbl_mem[0] = 8'd2; lbl_mem[1] = 8'd7; lbl_mem[2] = 8'd1;
    pred_mem[0] = 8'd2; pred_mem[1] = 8'd5; pred_mem[2] = 8'd1;
    for (int i = 0; i < 3; i++) dly_mem[i] = 4;
    run_seq(3, 1'b0, 1'b0, 0, 200);
    total++; if (obs_hung !== 0) $display("FAIL basic_hung: got %0d want 0", obs_hung); else passed++;
    total++; if (bus.correct_cnt !== 32'd2) $display("FAIL basic_correct: got %0d want 2", bus.correct_cnt); else passed++;
    total++; if (bus.tested_cnt !== 32'd3) $display("FAIL basic_tested: got %0d want 3", bus.tested_cnt); else passed++;
    total++; if (obs_starts !== 3 || obs_sel_bad !== 0) $display("FAIL basic_starts: got %0d (bad sel %0d) want 3 (0)", obs_starts, obs_sel_bad); else passed++;
    total++; if (obs_done_cnt !== 1) $display("FAIL basic_done_cnt: got %0d want 1", obs_done_cnt); else passed++;
    total++; if (obs_done_cyc !== 20) $display("FAIL basic_latency: got %0d want 20", obs_done_cyc); else passed++;
    total++; if (obs_busy_bad !== 0) $display("FAIL basic_busy: got %0d bad cycles want 0", obs_busy_bad); else passed++;
    total++; if (bus.test_sel !== 32'd3) $display("FAIL basic_sel_hold: got %0d want 3", bus.test_sel); else passed++;
  endtask

  task automatic test_cfg_err();
    int unsigned ns [2] = '{0, MaxT + 1};
    foreach (ns[k]) begin
      run_seq(ns[k], 1'b0, 1'b0, 0, 50);
      total++; if (obs_done_cyc !== 2 || obs_done_cnt !== 1) $display("FAIL cfg_done_n%0d: got cyc %0d cnt %0d want 2 1", ns[k], obs_done_cyc, obs_done_cnt); else passed++;
      total++; if (bus.cfg_err !== 1'b1) $display("FAIL cfg_flag_n%0d: got %b want 1", ns[k], bus.cfg_err); else passed++;
      total++; if (bus.correct_cnt !== 0 || bus.tested_cnt !== 0) $display("FAIL cfg_counts_n%0d: got %0d/%0d want 0/0", ns[k], bus.correct_cnt, bus.tested_cnt); else passed++;
      total++; if (obs_starts !== 0 || obs_busy_bad !== 0) $display("FAIL cfg_starts_n%0d: got starts %0d busybad %0d want 0 0", ns[k], obs_starts, obs_busy_bad); else passed++;
    end
  endtask

  task automatic test_timeout();
    fill(3, 3, 3);
    for (int i = 0; i < 3; i++) pred_mem[i] = lbl_mem[i];
    dly_mem[1] = Never;
    run_seq(3, 1'b0, 1'b0, 0, 200);
    total++; if (bus.timeout_err !== 1'b1) $display("FAIL to_flag: got %b want 1", bus.timeout_err); else passed++;
    total++; if (bus.tested_cnt !== 32'd3 || bus.correct_cnt !== 32'd2) $display("FAIL to_counts: got %0d/%0d want 2/3", bus.correct_cnt, bus.tested_cnt); else passed++;
    total++; if (obs_done_cyc !== exp_done_cyc(3) || obs_hung !== 0) $display("FAIL to_latency: got %0d want %0d", obs_done_cyc, exp_done_cyc(3)); else passed++;
    total++; if (bus.cfg_err !== 1'b0) $display("FAIL to_cfg_cleared: got %b want 0", bus.cfg_err); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int unsigned stray_done = 0;
    fill(10, 4, 4);
    run_seq(10, 1'b0, 1'b0, 5, 400);
    total++; if (obs_starts !== 5 || obs_hung !== 0) $display("FAIL rst_abort_point: got starts %0d hung %0d want 5 0", obs_starts, obs_hung); else passed++;
    total++; if (bus.busy !== 1'b0 || bus.test_sel !== 32'd1 || bus.nn_start !== 1'b0) $display("FAIL rst_mid_state: got busy %b sel %0d nn_start %b want 0 1 0", bus.busy, bus.test_sel, bus.nn_start); else passed++;
    total++; if (bus.tested_cnt !== 0 || bus.correct_cnt !== 0 || bus.timeout_err !== 1'b0) $display("FAIL rst_mid_counts: got %0d/%0d to %b want 0/0 0", bus.correct_cnt, bus.tested_cnt, bus.timeout_err); else passed++;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.nn_start !== 1'b0) stray_done++;
    end
    total++; if (stray_done !== 0) $display("FAIL rst_no_done: got %0d strobes want 0", stray_done); else passed++;
    fill(4, 1, 6);
    run_seq(4, 1'b0, 1'b0, 0, 200);
    total++; if (bus.correct_cnt !== exp_correct(4) || bus.tested_cnt !== 32'd4) $display("FAIL rst_fresh_counts: got %0d/%0d want %0d/4", bus.correct_cnt, bus.tested_cnt, exp_correct(4)); else passed++;
  endtask

  task automatic test_start_held_stray();
    int unsigned starts = 0;
    fill(3, 2, 5);
    run_seq(3, 1'b0, 1'b1, 0, 200);
    bus.nn_pred = 8'hAA;
    repeat (4) begin
      bus.nn_done = 1'b1;
      @(posedge clk);
      #1;
      if (bus.nn_start === 1'b1) starts++;
    end
    bus.nn_done = 1'b0;
    total++; if (bus.tested_cnt !== 32'd3 || bus.correct_cnt !== exp_correct(3) || starts !== 0) $display("FAIL stray_idle: got %0d/%0d starts %0d want %0d/3 0", bus.correct_cnt, bus.tested_cnt, starts, exp_correct(3)); else passed++;
    fill(5, 1, 5);
    run_seq(5, 1'b1, 1'b1, 0, 200);
    total++; if (obs_starts !== 5 || obs_done_cnt !== 1 || obs_sel_bad !== 0) $display("FAIL held_single_run: got starts %0d dones %0d badsel %0d want 5 1 0", obs_starts, obs_done_cnt, obs_sel_bad); else passed++;
    total++; if (bus.correct_cnt !== exp_correct(5) || bus.tested_cnt !== 32'd5) $display("FAIL held_counts: got %0d/%0d want %0d/5", bus.correct_cnt, bus.tested_cnt, exp_correct(5)); else passed++;
    total++; if (obs_busy_bad !== 0 || obs_done_cyc !== exp_done_cyc(5)) $display("FAIL held_timing: got busybad %0d cyc %0d want 0 %0d", obs_busy_bad, obs_done_cyc, exp_done_cyc(5)); else passed++;
  endtask

  task automatic test_full_depth();
    fill(MaxT, TO, TO);
    for (int i = 0; i < int'(MaxT); i++) pred_mem[i] = lbl_mem[i];
    run_seq(MaxT, 1'b0, 1'b0, 0, exp_done_cyc(MaxT) + 20);
    total++; if (bus.correct_cnt !== MaxT || bus.tested_cnt !== MaxT) $display("FAIL full_counts: got %0d/%0d want %0d/%0d", bus.correct_cnt, bus.tested_cnt, MaxT, MaxT); else passed++;
    total++; if (bus.timeout_err !== 1'b0 || bus.cfg_err !== 1'b0) $display("FAIL full_flags: got to %b cfg %b want 0 0", bus.timeout_err, bus.cfg_err); else passed++;
    total++; if (obs_done_cyc !== exp_done_cyc(MaxT) || obs_starts !== MaxT) $display("FAIL full_timing: got cyc %0d starts %0d want %0d %0d", obs_done_cyc, obs_starts, exp_done_cyc(MaxT), MaxT); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      int unsigned n = $urandom_range(1, 24);
      fill(n, 1, TO + 3);
      run_seq(n, 1'b0, 1'b0, 0, exp_done_cyc(n) + 20);
      total++; if (bus.correct_cnt !== exp_correct(n) || bus.tested_cnt !== n) $display("FAIL b2b%0d_counts: got %0d/%0d want %0d/%0d", r, bus.correct_cnt, bus.tested_cnt, exp_correct(n), n); else passed++;
      total++; if (bus.timeout_err !== exp_timeout(n)) $display("FAIL b2b%0d_timeout: got %b want %b", r, bus.timeout_err, exp_timeout(n)); else passed++;
      total++; if (obs_done_cyc !== exp_done_cyc(n) || obs_starts !== n || bus.test_sel !== n) $display("FAIL b2b%0d_seq: got cyc %0d starts %0d sel %0d want %0d %0d %0d", r, obs_done_cyc, obs_starts, bus.test_sel, exp_done_cyc(n), n, n); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      lbl_mem[i] = '0; pred_mem[i] = '0; dly_mem[i] = 1;
    end
    test_reset();
    test_basic();
    test_cfg_err();
    test_timeout();
    test_reset_mid_run();
    test_start_held_stray();
    test_full_depth();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
